// File: rtl/stdout_reader.sv
// Pops tagged stdout entries from a FWFT FIFO and serialises them as bytes, optionally framed
// with an A5/cluster/core header whenever the source changes (enabled by STDOUT_READER_HDR_EN).
module stdout_reader #(
   parameter int N_CLUSTERS = 1,
   parameter int N_CORES    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fifo_empty_i,
   input  logic [31:0] fifo_dout_i,
   output logic        fifo_rd_en_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic [15:0] drop_cnt_o
);

   typedef enum logic [2:0] {IDLE, HDR_SYNC, HDR_CL, HDR_CORE, CHAR} state_t;

   localparam logic [7:0] CL_LIM   = 8'(N_CLUSTERS);
   localparam logic [7:0] CORE_LIM = 8'(N_CORES);
   localparam logic [7:0] SYNC     = 8'hA5;
   localparam logic [7:0] NEWLINE  = 8'h0A;

   state_t      state;
   logic [23:0] entry;
   logic        in_range;
   logic        handshake;
   logic [7:0]  unused_hi;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign unused_hi    = fifo_dout_i[31:24];
   // Gated by rst_i so no pop can slip through while reset is held.
   assign fifo_rd_en_o = (state == IDLE) && !fifo_empty_i && !rst_i;
   assign in_range     = (fifo_dout_i[23:16] < CL_LIM) && (fifo_dout_i[15:8] < CORE_LIM);
   assign handshake    = tx_valid_o && tx_ready_i;

`ifdef STDOUT_READER_HDR_EN
   logic        last_valid;
   logic [15:0] last_src;
   logic        need_hdr;

   assign need_hdr = !last_valid || (last_src != fifo_dout_i[23:8]);
`else
   logic unused_src;

   assign unused_src = ^entry[23:8];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         entry      <= '0;
         tx_valid_o <= 1'b0;
         tx_data_o  <= '0;
         drop_cnt_o <= '0;
`ifdef STDOUT_READER_HDR_EN
         last_valid <= 1'b0;
         last_src   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_rd_en_o) begin
                  entry <= fifo_dout_i[23:0];
                  if (!in_range) begin
                     drop_cnt_o <= sat_inc(drop_cnt_o);
                  end else begin
                     tx_valid_o <= 1'b1;
`ifdef STDOUT_READER_HDR_EN
                     if (need_hdr) begin
                        state     <= HDR_SYNC;
                        tx_data_o <= SYNC;
                     end else begin
                        state     <= CHAR;
                        tx_data_o <= fifo_dout_i[7:0];
                     end
`else
                     state     <= CHAR;
                     tx_data_o <= fifo_dout_i[7:0];
`endif
                  end
               end
            end
            HDR_SYNC: if (handshake) begin
               state     <= HDR_CL;
               tx_data_o <= entry[23:16];
            end
            HDR_CL: if (handshake) begin
               state     <= HDR_CORE;
               tx_data_o <= entry[15:8];
            end
            HDR_CORE: if (handshake) begin
               state     <= CHAR;
               tx_data_o <= entry[7:0];
            end
            CHAR: if (handshake) begin
               state      <= IDLE;
               tx_valid_o <= 1'b0;
`ifdef STDOUT_READER_HDR_EN
               // A newline ends the line, so the next char always re-announces its source.
               last_src   <= entry[23:8];
               last_valid <= (entry[7:0] != NEWLINE);
`endif
            end
            default: begin
               state      <= IDLE;
               tx_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stdout_reader.sv
// Scoreboard bench for stdout_reader: a FIFO model feeds directed words, a monitor checks
// every accepted output byte against the expected-byte queue.
module tb_stdout_reader;

`ifdef STDOUT_READER_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_dout = '0;
   logic        fifo_rd_en;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] drop_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] fifo_q[$];
   logic [7:0]  exp_q[$];
   logic        rd_seen = 1'b0;
   logic        stream_bad = 1'b0;
   logic [7:0]  mon_exp;
   logic [7:0]  hold_val;
   bit          found;

   always #5 clk = ~clk;

   stdout_reader #(.N_CLUSTERS(1), .N_CORES(8)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .fifo_empty_i(fifo_empty),
      .fifo_dout_i(fifo_dout),
      .fifo_rd_en_o(fifo_rd_en),
      .tx_data_o(tx_data),
      .tx_valid_o(tx_valid),
      .tx_ready_i(tx_ready),
      .drop_cnt_o(drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // FWFT FIFO model: the pop decision is sampled mid-cycle, head/empty change after the edge.
   always @(negedge clk) rd_seen <= fifo_rd_en;

   always @(posedge clk) begin
      if (rd_seen && !stream_bad && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (stream_bad) begin
         fifo_empty <= 1'b0;
         fifo_dout  <= 32'h0000_0941;
      end else begin
         fifo_empty <= (fifo_q.size() == 0);
         fifo_dout  <= (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      end
   end

   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %h, expected no byte", tx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("tx_byte", {24'h0, tx_data}, {24'h0, mon_exp});
         end
      end
   end

   task automatic expect_hdr(input logic [7:0] cl, input logic [7:0] core);
      if (HDR) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(cl);
         exp_q.push_back(core);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && fifo_q.size() == 0 && !tx_valid) done = 1'b1;
      end
      check("drain_left", exp_q.size(), 0);
      cyc(1);
   endtask

   initial begin
      rst = 1'b1;
      tx_ready = 1'b1;
      fifo_q.push_back(32'h0000_0148);
      cyc(3);
      check("rst_rd_en", {31'h0, fifo_rd_en}, 0);
      check("rst_valid", {31'h0, tx_valid}, 0);
      check("rst_data", {24'h0, tx_data}, 0);
      check("rst_drop", {16'h0, drop_cnt}, 0);

      // Header, same-source char, newline, fresh line, source change.
      expect_hdr(8'h00, 8'h01); exp_q.push_back(8'h48);
      exp_q.push_back(8'h49);
      exp_q.push_back(8'h0A);
      expect_hdr(8'h00, 8'h01); exp_q.push_back(8'h41);
      expect_hdr(8'h00, 8'h02); exp_q.push_back(8'h49);
      fifo_q.push_back(32'h0000_0149);
      fifo_q.push_back(32'h0000_010A);
      fifo_q.push_back(32'h0000_0141);
      fifo_q.push_back(32'h0000_0249);
      rst = 1'b0;
      drain();

      // Out-of-range core, then out-of-range cluster.
      fifo_q.push_back(32'h0000_0941);
      cyc(5);
      check("drop_core", {16'h0, drop_cnt}, 1);
      fifo_q.push_back(32'h0001_0041);
      cyc(5);
      check("drop_cluster", {16'h0, drop_cnt}, 2);
      check("drop_no_valid", {31'h0, tx_valid}, 0);

      // Reset in the middle of a frame.
      if (HDR) begin
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'h00);
         fifo_q.push_back(32'h0000_0342);
         found = 1'b0;
         for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h00) found = 1'b1;
         end
         @(posedge clk); #1;
         tx_ready = 1'b0;
         check("pre_rst_core", {24'h0, tx_data}, 32'h03);
      end else begin
         tx_ready = 1'b0;
         fifo_q.push_back(32'h0000_0342);
         found = 1'b0;
         for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_valid) found = 1'b1;
         end
         @(posedge clk); #1;
         check("pre_rst_char", {24'h0, tx_data}, 32'h42);
      end
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'h0, tx_valid}, 0);
      check("midrst_data", {24'h0, tx_data}, 0);
      check("midrst_drop", {16'h0, drop_cnt}, 0);
      cyc(2);
      rst = 1'b0;
      tx_ready = 1'b1;
      expect_hdr(8'h00, 8'h01); exp_q.push_back(8'h48);
      fifo_q.push_back(32'h0000_0148);
      drain();

      // Backpressure: output must hold while ready is low, no further pop.
      expect_hdr(8'h00, 8'h04); exp_q.push_back(8'h43);
      exp_q.push_back(8'h44);
      if (!HDR) tx_ready = 1'b0;
      fifo_q.push_back(32'h0000_0443);
      fifo_q.push_back(32'h0000_0444);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (tx_valid && (!HDR || tx_data == 8'hA5)) found = 1'b1;
      end
      @(posedge clk); #1;
      tx_ready = 1'b0;
      hold_val = HDR ? 8'h00 : 8'h43;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'h0, tx_valid}, 1);
         check("stall_data", {24'h0, tx_data}, {24'h0, hold_val});
         check("stall_no_pop", {31'h0, fifo_rd_en}, 0);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      drain();

      // Counter saturation under a continuous stream of bad entries.
      stream_bad = 1'b1;
      for (int i = 0; i < 70000 && drop_cnt != 16'hFFFF; i++) @(posedge clk);
      cyc(5);
      check("drop_saturate", {16'h0, drop_cnt}, 32'hFFFF);
      stream_bad = 1'b0;
      cyc(3);
      check("sat_no_valid", {31'h0, tx_valid}, 0);
      check("end_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
